req_ack_delay_n: RTL and testbench

REQ_ACK_DELAY_N -- requirements
Module: req_ack_delay_n

---
 rtl/req_ack_delay_n.sv | 111 +++++++++++
 tb/tb_req_ack_delay_n.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_delay_n.sv
// req_ack_delay_n: per-channel req->ack delay line with runtime latency.
// Level mode delays req; pulse mode turns rising edges into 1-cycle acks.
module req_ack_delay_n #(
  parameter int NCH = 4,
  parameter int MAX_LAT = 8,
  parameter bit PULSE_MODE = 1'b0,
  localparam int LW = $clog2(MAX_LAT + 1)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] req,
  input  logic [LW-1:0]  lat,
  output logic [NCH-1:0] ack,
  output logic [NCH-1:0] busy,
  output logic           err
);

  localparam int LN = 1 << LW;

  logic [LW-1:0]  leff;
  logic [LW-1:0]  lat_q;
  logic [NCH-1:0] req_q;
  logic [NCH-1:0] in0;
  logic [NCH-1:0] bsy_v;
  logic [NCH-1:0] cnt_nz;
  logic           err_q;

  // Clamp the requested latency into 1..MAX_LAT.
  always_comb begin
    leff = lat;
    if (lat == '0) begin
      leff = LW'(1);
    end else if (lat > LW'(MAX_LAT)) begin
      leff = LW'(MAX_LAT);
    end
  end

  assign in0 = req & ~(req_q & {NCH{PULSE_MODE}});

  // Previous sampled req, for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) req_q <= '0;
    else       req_q <= req;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [MAX_LAT-1:0] sh;
    logic [LN-1:0]      nxt;
    logic [LN-1:0]      now;
    logic               cur;
    logic               a_q;
    logic               b_q;
    logic [LW-1:0]      cnt;
    logic [LW-1:0]      cnt_n;

    assign nxt = LN'({sh[MAX_LAT-2:0], in0[g]});
    assign now = LN'(sh);
    assign cur = now[leff - LW'(1)];

    // Shift line; ack is the tap of the line after this edge.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        sh  <= '0;
        a_q <= 1'b0;
      end else begin
        sh  <= nxt[MAX_LAT-1:0];
        a_q <= nxt[leff - LW'(1)];
      end
    end

    // Outstanding count: edge in, tap out, saturating.
    always_comb begin
      cnt_n = cnt;
      if (in0[g] && !cur && cnt != LW'(MAX_LAT)) begin
        cnt_n = cnt + LW'(1);
      end else if (!in0[g] && cur && cnt != '0) begin
        cnt_n = cnt - LW'(1);
      end
    end

    // Counter and registered busy flag.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        cnt <= '0;
        b_q <= 1'b0;
      end else begin
        cnt <= cnt_n;
        b_q <= (cnt_n != '0);
      end
    end

    assign ack[g]    = a_q;
    assign bsy_v[g]  = b_q;
    assign cnt_nz[g] = (cnt != '0);
  end

  // Sticky flag for latency changes while anything is in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat_q <= lat;
      err_q <= 1'b0;
    end else begin
      lat_q <= lat;
      if (lat != lat_q && |cnt_nz) err_q <= 1'b1;
    end
  end

  assign busy = bsy_v & {NCH{PULSE_MODE}};
  assign err  = err_q & PULSE_MODE;

endmodule

// File: tb/tb_req_ack_delay_n.sv
// tb_req_ack_delay_n: directed scenarios plus randomized run
// against an edge-history reference model, both modes at once.
module tb_req_ack_delay_n;

  localparam int NCH = 4;
  localparam int ML  = 8;
  localparam int LW  = 4;
  localparam int HN  = 4096;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [NCH-1:0] req = '0;
  logic [LW-1:0]  lat = 4'd3;
  logic [NCH-1:0] ack0, busy0, ack1, busy1;
  logic           err0, err1;

  int checks = 0;
  int failures = 0;

  req_ack_delay_n #(.NCH(NCH), .MAX_LAT(ML), .PULSE_MODE(1'b0)) u0 (
    .clk(clk), .rstn(rstn), .req(req), .lat(lat),
    .ack(ack0), .busy(busy0), .err(err0)
  );

  req_ack_delay_n #(.NCH(NCH), .MAX_LAT(ML), .PULSE_MODE(1'b1)) u1 (
    .clk(clk), .rstn(rstn), .req(req), .lat(lat),
    .ack(ack1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  // Reference model: histories of sampled req and rising edges per edge
  logic [NCH-1:0] rh [HN];
  logic [NCH-1:0] eh [HN];
  int             n = 0;
  int             rst_e = 0;
  int             m_cnt [NCH];
  logic [LW-1:0]  m_latp = '0;
  logic [NCH-1:0] m_ack0 = '0, m_ack1 = '0, m_busy = '0;
  logic           m_err = 1'b0;

  function automatic logic [NCH-1:0] get_r(int k);
    return (k > rst_e) ? rh[k] : '0;
  endfunction

  function automatic logic [NCH-1:0] get_e(int k);
    return (k > rst_e) ? eh[k] : '0;
  endfunction

  function automatic int clamp(logic [LW-1:0] v);
    if (v == 0) return 1;
    if (int'(v) > ML) return ML;
    return int'(v);
  endfunction

  always @(posedge clk) begin : model
    int L;
    bit any;
    logic [NCH-1:0] pv, cur;
    n = n + 1;
    rh[n] = req;
    if (!rstn) begin
      rst_e = n;
      eh[n] = '0;
      m_ack0 = '0;
      m_ack1 = '0;
      m_busy = '0;
      m_err = 1'b0;
      m_latp = lat;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    end else begin
      L = clamp(lat);
      pv = (n - 1 > rst_e) ? rh[n-1] : '0;
      eh[n] = req & ~pv;
      m_ack0 = get_r(n - L + 1);
      m_ack1 = get_e(n - L + 1);
      cur = get_e(n - L);
      any = 1'b0;
      for (int c = 0; c < NCH; c++) if (m_cnt[c] != 0) any = 1'b1;
      if (lat != m_latp && any) m_err = 1'b1;
      m_latp = lat;
      for (int c = 0; c < NCH; c++) begin
        if (eh[n][c] && !cur[c]) begin
          if (m_cnt[c] < ML) m_cnt[c] = m_cnt[c] + 1;
        end else if (!eh[n][c] && cur[c]) begin
          if (m_cnt[c] > 0) m_cnt[c] = m_cnt[c] - 1;
        end
        m_busy[c] = (m_cnt[c] != 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(int k);
    req = '0;
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (ack0 !== 4'b0 || ack1 !== 4'b0) begin
      failures++;
      $display("FAIL rst_ack got=%h/%h exp=0/0", ack0, ack1);
    end
    checks++;
    if (busy1 !== 4'b0 || err1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_err got=%h/%b exp=0/0", busy1, err1);
    end
    checks++;
    if (busy0 !== 4'b0 || err0 !== 1'b0) begin
      failures++;
      $display("FAIL tied_zero got=%h/%b exp=0/0", busy0, err0);
    end
    req = '0;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_level_lat3();
    logic [NCH-1:0] exp;
    lat = 4'd3;
    flush(12);
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      req = '0;
      exp = (k == 2) ? 4'b0001 : 4'b0000;
      checks++;
      if (ack0 !== exp) begin
        failures++;
        $display("FAIL lat3_ack0 k=%0d got=%h exp=%h", k, ack0, exp);
      end
      checks++;
      if (ack1 !== exp) begin
        failures++;
        $display("FAIL lat3_ack1 k=%0d got=%h exp=%h", k, ack1, exp);
      end
    end
  endtask

  task automatic test_lat_clamp();
    logic [NCH-1:0] exp;
    lat = 4'd0;
    flush(12);
    req = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      tick();
      req = '0;
      exp = (k == 0) ? 4'b1000 : 4'b0000;
      checks++;
      if (ack0 !== exp) begin
        failures++;
        $display("FAIL lat0_ack0 k=%0d got=%h exp=%h", k, ack0, exp);
      end
    end
    lat = 4'd15;
    flush(12);
    req = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      tick();
      req = '0;
      exp = (k == 7) ? 4'b1000 : 4'b0000;
      checks++;
      if (ack0 !== exp) begin
        failures++;
        $display("FAIL lat15_ack0 k=%0d got=%h exp=%h", k, ack0, exp);
      end
    end
  endtask

  task automatic test_pulse_hold();
    logic [NCH-1:0] ea, eb;
    lat = 4'd4;
    flush(12);
    for (int k = 1; k <= 12; k++) begin
      req = (k <= 10) ? 4'b0010 : 4'b0000;
      tick();
      ea = (k == 4) ? 4'b0010 : 4'b0000;
      eb = (k <= 4) ? 4'b0010 : 4'b0000;
      checks++;
      if (ack1 !== ea) begin
        failures++;
        $display("FAIL hold_ack1 k=%0d got=%h exp=%h", k, ack1, ea);
      end
      checks++;
      if (busy1 !== eb) begin
        failures++;
        $display("FAIL hold_busy1 k=%0d got=%h exp=%h", k, busy1, eb);
      end
    end
  endtask

  task automatic test_pulse_toggle();
    logic [NCH-1:0] ea, eb;
    lat = 4'd5;
    flush(12);
    for (int k = 1; k <= 16; k++) begin
      req = (k <= 10 && (k % 2) == 1) ? 4'b0100 : 4'b0000;
      tick();
      ea = (k >= 5 && k <= 13 && (k % 2) == 1) ? 4'b0100 : 4'b0000;
      eb = (k <= 13) ? 4'b0100 : 4'b0000;
      checks++;
      if (ack1 !== ea) begin
        failures++;
        $display("FAIL toggle_ack1 k=%0d got=%h exp=%h", k, ack1, ea);
      end
      checks++;
      if (busy1 !== eb) begin
        failures++;
        $display("FAIL toggle_busy1 k=%0d got=%h exp=%h", k, busy1, eb);
      end
    end
  endtask

  task automatic test_err();
    lat = 4'd4;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    flush(3);
    lat = 4'd6;
    tick();
    lat = 4'd4;
    tick();
    checks++;
    if (err1 !== 1'b0) begin
      failures++;
      $display("FAIL err_idle got=%b exp=0", err1);
    end
    req = 4'b0001;
    tick();
    req = '0;
    lat = 4'd6;
    tick();
    checks++;
    if (err1 !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%b exp=1", err1);
    end
    flush(10);
    checks++;
    if (err1 !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", err1);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (err1 !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got=%b exp=0", err1);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    lat = 4'd6;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    flush(2);
    req = 4'b1111;
    tick();
    req = '0;
    tick();
    checks++;
    if (busy1 !== 4'b1111) begin
      failures++;
      $display("FAIL mid_busy_pre got=%h exp=f", busy1);
    end
    rstn = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) rstn = 1'b1;
      tick();
      checks++;
      if (ack0 !== 4'b0 || ack1 !== 4'b0 || busy1 !== 4'b0 || err1 !== 1'b0) begin
        failures++;
        $display("FAIL mid_drop k=%0d got=%h/%h/%h/%b exp=0/0/0/0",
                 k, ack0, ack1, busy1, err1);
      end
    end
  endtask

  task automatic test_reset_release();
    logic [NCH-1:0] exp;
    lat = 4'd2;
    req = 4'b0001;
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = (k == 2) ? 4'b0001 : 4'b0000;
      checks++;
      if (ack1 !== exp) begin
        failures++;
        $display("FAIL release_ack1 k=%0d got=%h exp=%h", k, ack1, exp);
      end
    end
    flush(10);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req = NCH'($urandom & $urandom);
      if ($urandom_range(0, 9) == 0) lat = LW'($urandom_range(0, 15));
      rstn = ($urandom_range(0, 59) != 0);
      tick();
      checks++;
      if (ack0 !== m_ack0) begin
        failures++;
        $display("FAIL rnd_ack0 i=%0d got=%h exp=%h", i, ack0, m_ack0);
      end
      checks++;
      if (ack1 !== m_ack1) begin
        failures++;
        $display("FAIL rnd_ack1 i=%0d got=%h exp=%h", i, ack1, m_ack1);
      end
      checks++;
      if (busy1 !== m_busy) begin
        failures++;
        $display("FAIL rnd_busy1 i=%0d got=%h exp=%h", i, busy1, m_busy);
      end
      checks++;
      if (err1 !== m_err) begin
        failures++;
        $display("FAIL rnd_err1 i=%0d got=%b exp=%b", i, err1, m_err);
      end
      checks++;
      if (busy0 !== 4'b0 || err0 !== 1'b0) begin
        failures++;
        $display("FAIL rnd_tied i=%0d got=%h/%b exp=0/0", i, busy0, err0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_level_lat3();
    test_lat_clamp();
    test_pulse_hold();
    test_pulse_toggle();
    test_err();
    test_reset_mid();
    test_reset_release();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
